// File: rtl/als_display_pkg.sv
// Shared constants and types for the ALS display path: BCD digit width,
// double-dabble adjust constants and the converter state encoding.
package als_display_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble digit correction: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next decade.
module bcd_digit_adj
    import als_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? digit_in + BCD_ADJ_ADD : digit_in;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one adjust+shift step per clock.
// Optional leading-zero blanking mask is built when ALS_LZ_BLANK_EN is defined.
module bin_to_bcd_serial
    import als_display_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGITS*DIGIT_W-1:0] bcd_out,
    output logic                      overflow,
    output logic [DIGITS-1:0]         blank_mask
);

    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    bcd_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic               sticky_q, sticky_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   scratch_adj;
    logic [BCD_W-1:0]   shift_scratch;
    logic               shift_ovf;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .digit_out (scratch_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // The bit leaving the top digit on this shift is lost precision: fold it into the sticky.
    assign shift_scratch = {scratch_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    assign shift_ovf     = sticky_q | scratch_adj[BCD_W-1];

`ifdef ALS_LZ_BLANK_EN
    logic [DIGITS-1:0] mask_q, mask_d;
    logic [DIGITS-1:0] mask_calc;
    logic              higher_zero;

    always_comb begin
        mask_calc   = '0;
        higher_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            higher_zero  = higher_zero & (shift_scratch[k*DIGIT_W +: DIGIT_W] == '0);
            mask_calc[k] = higher_zero;
        end
        if (shift_ovf) begin
            mask_calc    = '1;
            mask_calc[0] = 1'b0;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        sticky_d  = sticky_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
`ifdef ALS_LZ_BLANK_EN
        mask_d    = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    bin_d     = bin_in;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                scratch_d = shift_scratch;
                bin_d     = {bin_q[BIN_W-2:0], 1'b0};
                sticky_d  = shift_ovf;
                cnt_d     = cnt_q - 1'b1;
                // Results are registered on the last shift so they are valid alongside done.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ovf_d   = shift_ovf;
                    bcd_d   = shift_ovf ? '0 : shift_scratch;
`ifdef ALS_LZ_BLANK_EN
                    mask_d  = mask_calc;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
`ifdef ALS_LZ_BLANK_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            sticky_q  <= sticky_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
`ifdef ALS_LZ_BLANK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;
`ifdef ALS_LZ_BLANK_EN
    assign blank_mask = mask_q;
`else
    assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Self-checking bench for bin_to_bcd_serial: a 5-digit and a 4-digit instance
// checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        busy, done, overflow;
    logic [19:0] bcd_out;
    logic [4:0]  blank_mask;

    logic        start4 = 1'b0;
    logic [15:0] bin_in4 = '0;
    logic        busy4, done4, overflow4;
    logic [15:0] bcd_out4;
    logic [3:0]  blank_mask4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin_to_bcd_serial #(.BIN_W(16), .DIGITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow),
        .blank_mask(blank_mask)
    );

    bin_to_bcd_serial #(.BIN_W(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .bin_in(bin_in4),
        .busy(busy4), .done(done4), .bcd_out(bcd_out4), .overflow(overflow4),
        .blank_mask(blank_mask4)
    );

    // Reference: plain decimal digit extraction.
    function automatic void model(input int v, input int nd, output logic [19:0] bcd,
                                  output logic ovf, output logic [4:0] mask);
        int limit = 1;
        int nsig = 1;
        for (int k = 0; k < nd; k++) limit = limit * 10;
        bcd  = '0;
        mask = '0;
        ovf  = (v >= limit);
        if (ovf) begin
            mask = 5'b11110;
        end else begin
            int t = v;
            for (int k = 0; k < nd; k++) begin
                bcd[4*k +: 4] = 4'(t % 10);
                if (t != 0) nsig = k + 1;
                t = t / 10;
            end
            for (int k = 1; k < 5; k++) mask[k] = (k >= nsig);
        end
`ifndef ALS_LZ_BLANK_EN
        mask = '0;
`endif
    endfunction

    task automatic convert(input bit use4, input logic [15:0] v, output int lat, output int bcnt);
        @(negedge clk);
        if (use4) begin start4 = 1'b1; bin_in4 = v; end
        else begin start = 1'b1; bin_in = v; end
        @(negedge clk);
        start = 1'b0; start4 = 1'b0;
        bin_in = $urandom_range(0, 65535); bin_in4 = $urandom_range(0, 65535);
        lat = -1; bcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (use4 ? busy4 : busy) bcnt++;
            if (use4 ? done4 : done) begin lat = c; break; end
            @(negedge clk);
        end
    endtask

    task automatic check5(input string name, input int v, input bit chk_mask);
        logic [19:0] eb; logic eo; logic [4:0] em;
        model(v, 5, eb, eo, em);
        n_cmp++;
        if (bcd_out !== eb || overflow !== eo) begin
            n_err++;
            $display("FAIL %s v=%0d: got bcd=%h ovf=%b, want bcd=%h ovf=%b", name, v, bcd_out, overflow, eb, eo);
        end
        if (chk_mask) begin
            n_cmp++;
            if (blank_mask !== em) begin
                n_err++;
                $display("FAIL %s_mask v=%0d: got %b, want %b", name, v, blank_mask, em);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (busy !== 0 || done !== 0 || bcd_out !== 0 || overflow !== 0 || blank_mask !== 0 ||
            busy4 !== 0 || done4 !== 0 || bcd_out4 !== 0 || overflow4 !== 0) begin
            n_err++;
            $display("FAIL reset: got busy=%b done=%b bcd=%h ovf=%b mask=%b, want all 0",
                     busy, done, bcd_out, overflow, blank_mask);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency(input logic [15:0] v);
        int lat, bcnt;
        convert(1'b0, v, lat, bcnt);
        n_cmp++;
        if (lat != 17 || bcnt != 16) begin
            n_err++;
            $display("FAIL latency v=%0d: got done_cycle=%0d busy_cycles=%0d, want 17/16", v, lat, bcnt);
        end
        check5("latency_result", v, 1'b1);
    endtask

    task automatic test_digits4();
        int lat, bcnt;
        int vals[4] = '{9999, 10000, 0, 65535};
        for (int i = 0; i < 8; i++) begin
            logic [19:0] eb; logic eo; logic [4:0] em;
            int v = (i < 4) ? vals[i] : int'($urandom_range(0, 20000));
            convert(1'b1, 16'(v), lat, bcnt);
            model(v, 4, eb, eo, em);
            n_cmp++;
            if (lat != 17 || bcd_out4 !== eb[15:0] || overflow4 !== eo) begin
                n_err++;
                $display("FAIL digits4 v=%0d: got lat=%0d bcd=%h ovf=%b, want lat=17 bcd=%h ovf=%b",
                         v, lat, bcd_out4, overflow4, eb[15:0], eo);
            end
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        for (int i = 0; i < 20; i++) begin
            int v = (i % 4 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 65535));
            convert(1'b0, 16'(v), lat, bcnt);
            n_cmp++;
            if (lat != 17) begin
                n_err++;
                $display("FAIL random_lat v=%0d: got %0d, want 17", v, lat);
            end
            check5("random", v, 1'b1);
        end
    endtask

    task automatic test_ignored_start();
        int n_done = 0, done_cyc = -1, busy_after = 0;
        @(negedge clk);
        start = 1'b1; bin_in = 16'd1234;
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            if (done) begin n_done++; done_cyc = c; end
            if (busy && c > 17) busy_after++;
            start  = (c == 5 || c == 17);
            bin_in = 16'd777;
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (n_done != 1 || done_cyc != 17 || busy_after != 0) begin
            n_err++;
            $display("FAIL ignored_start: got dones=%0d at=%0d busy_after=%0d, want 1 at 17, 0",
                     n_done, done_cyc, busy_after);
        end
        check5("ignored_start", 1234, 1'b0);
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, n_done = 0;
        @(negedge clk);
        start = 1'b1; bin_in = 16'd4321;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 8; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 0 || bcd_out !== 0 || done !== 0 || overflow !== 0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b bcd=%h done=%b ovf=%b, want 0", busy, bcd_out, done, overflow);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (done || busy) n_done++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_done != 0) begin
            n_err++;
            $display("FAIL reset_resume: got %0d active cycles, want 0", n_done);
        end
        convert(1'b0, 16'd4321, lat, bcnt);
        n_cmp++;
        if (lat != 17) begin
            n_err++;
            $display("FAIL reset_restart_lat: got %0d, want 17", lat);
        end
        check5("reset_restart", 4321, 1'b1);
    endtask

    task automatic test_blank();
        int lat, bcnt;
        convert(1'b0, 16'd42, lat, bcnt);
        check5("blank42", 42, 1'b1);
        convert(1'b0, 16'd0, lat, bcnt);
        check5("blank0", 0, 1'b1);
        convert(1'b0, 16'd10000, lat, bcnt);
        check5("blank10000", 10000, 1'b1);
    endtask

    initial begin
        test_reset();
        test_latency(16'd0);
        test_latency(16'd65535);
        test_digits4();
        test_random();
        test_ignored_start();
        test_reset_mid();
        test_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
